// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EXE forwarding selects, load-use stall, branch flush.
// Mirrors the EX/MEM/WB destination info in shadow registers and gates pipeline progress.
module hazard_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid,
  input  logic [4:0]  rs1_id,
  input  logic [4:0]  rs2_id,
  input  logic [4:0]  rd_id,
  input  logic        use_rs1_id,
  input  logic        use_rs2_id,
  input  logic        regwrite_id,
  input  logic        memread_id,
  input  logic        redirect_exe,
  input  logic        mem_busy,
  output logic [1:0]  forward_rd1_exe,
  output logic [1:0]  forward_rd2_exe,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        flush_exe,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN        = 2'b00,
    LOAD_STALL = 2'b01,
    FLUSH      = 2'b10
  } state_t;

  state_t state_q, state_d;

  logic       ex_v, ex_use1, ex_use2, ex_rw, ex_mr;
  logic [4:0] ex_rs1, ex_rs2, ex_rd;
  logic       mem_v, mem_rw;
  logic [4:0] mem_rd;
  logic       wb_v, wb_rw;
  logic [4:0] wb_rd;
  logic       load_use;

  assign state = state_q;

  assign load_use = id_valid && ex_v && ex_mr && (ex_rd != 5'd0) &&
                    ((use_rs1_id && (rs1_id == ex_rd)) ||
                     (use_rs2_id && (rs2_id == ex_rd)));

  // MEM is younger than WB, so its result wins; x0 is hardwired and never forwarded.
  always_comb begin
    forward_rd1_exe = 2'b00;
    forward_rd2_exe = 2'b00;
    if (ex_use1 && mem_v && mem_rw && (mem_rd != 5'd0) && (mem_rd == ex_rs1))
      forward_rd1_exe = 2'b01;
    else if (ex_use1 && wb_v && wb_rw && (wb_rd != 5'd0) && (wb_rd == ex_rs1))
      forward_rd1_exe = 2'b10;
    if (ex_use2 && mem_v && mem_rw && (mem_rd != 5'd0) && (mem_rd == ex_rs2))
      forward_rd2_exe = 2'b01;
    else if (ex_use2 && wb_v && wb_rw && (wb_rd != 5'd0) && (wb_rd == ex_rs2))
      forward_rd2_exe = 2'b10;
  end

  // state_d is the mode of the cycle now executing; the register records it at the edge,
  // so the controls below act in the very cycle the hazard is seen.
  always_comb begin
    state_d   = RUN;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    flush_id  = 1'b0;
    flush_exe = 1'b0;
    case (state_q)
      RUN:        state_d = redirect_exe ? FLUSH : (load_use ? LOAD_STALL : RUN);
      LOAD_STALL: state_d = redirect_exe ? FLUSH : RUN;
      FLUSH:      state_d = RUN;
      default:    state_d = RUN;
    endcase
    if (mem_busy) begin
      stall_if = 1'b1;
      stall_id = 1'b1;
    end else begin
      case (state_d)
        LOAD_STALL: begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          flush_exe = 1'b1;
        end
        FLUSH: begin
          flush_id  = 1'b1;
          flush_exe = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A busy data memory freezes everything, including the stall counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= RUN;
      stall_count <= 16'd0;
      ex_v <= 1'b0; ex_use1 <= 1'b0; ex_use2 <= 1'b0; ex_rw <= 1'b0; ex_mr <= 1'b0;
      ex_rs1 <= 5'd0; ex_rs2 <= 5'd0; ex_rd <= 5'd0;
      mem_v <= 1'b0; mem_rw <= 1'b0; mem_rd <= 5'd0;
      wb_v  <= 1'b0; wb_rw  <= 1'b0; wb_rd  <= 5'd0;
    end else if (!mem_busy) begin
      state_q <= state_d;
      wb_v    <= mem_v;
      wb_rw   <= mem_rw;
      wb_rd   <= mem_rd;
      mem_v   <= ex_v;
      mem_rw  <= ex_rw;
      mem_rd  <= ex_rd;
      ex_rs1  <= rs1_id;
      ex_rs2  <= rs2_id;
      ex_rd   <= rd_id;
      ex_use1 <= use_rs1_id;
      ex_use2 <= use_rs2_id;
      if (state_d == RUN) begin
        ex_v  <= id_valid;
        ex_rw <= regwrite_id;
        ex_mr <= memread_id;
      end else begin
        ex_v  <= 1'b0;
        ex_rw <= 1'b0;
        ex_mr <= 1'b0;
      end
      if ((state_d == LOAD_STALL) && (stall_count != 16'hFFFF))
        stall_count <= stall_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed testbench for hazard_ctrl: forwarding, load-use stall, redirect flush,
// memory-busy freeze, counter saturation and asynchronous reset.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic        use_rs1_id, use_rs2_id, regwrite_id, memread_id;
  logic        redirect_exe, mem_busy;
  logic [1:0]  forward_rd1_exe, forward_rd2_exe;
  logic        stall_if, stall_id, flush_id, flush_exe;
  logic [1:0]  state;
  logic [15:0] stall_count;

  int total = 0;
  int bad   = 0;

  hazard_ctrl dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .use_rs1_id(use_rs1_id), .use_rs2_id(use_rs2_id),
    .regwrite_id(regwrite_id), .memread_id(memread_id),
    .redirect_exe(redirect_exe), .mem_busy(mem_busy),
    .forward_rd1_exe(forward_rd1_exe), .forward_rd2_exe(forward_rd2_exe),
    .stall_if(stall_if), .stall_id(stall_id), .flush_id(flush_id), .flush_exe(flush_exe),
    .state(state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Control outputs packed as {stall_if, stall_id, flush_id, flush_exe}.
  function automatic logic [3:0] ctrl();
    return {stall_if, stall_id, flush_id, flush_exe};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                        input logic [4:0] rd, input logic u1, input logic u2,
                        input logic rw, input logic mr);
    id_valid = v; rs1_id = r1; rs2_id = r2; rd_id = rd;
    use_rs1_id = u1; use_rs2_id = u2; regwrite_id = rw; memread_id = mr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_exe = 1'b0;
    mem_busy = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (ctrl() !== 4'b0000) begin bad++; $display("FAIL reset_ctrl: got %b want 0000", ctrl()); end
    total++; if (state !== 2'b00) begin bad++; $display("FAIL reset_state: got %b want 00", state); end
    total++; if ({forward_rd1_exe, forward_rd2_exe} !== 4'b0000) begin bad++; $display("FAIL reset_fwd: got %b want 0000", {forward_rd1_exe, forward_rd2_exe}); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0h want 0", stall_count); end
  endtask

  task automatic test_forward_mem();
    do_reset();
    set_id(1, 1, 2, 5, 1, 1, 1, 0);
    tick();
    set_id(1, 5, 6, 8, 1, 1, 1, 0);
    tick();
    total++; if (forward_rd1_exe !== 2'b01) begin bad++; $display("FAIL fwd_mem_rs1: got %b want 01", forward_rd1_exe); end
    total++; if (forward_rd2_exe !== 2'b00) begin bad++; $display("FAIL fwd_mem_rs2: got %b want 00", forward_rd2_exe); end
  endtask

  task automatic test_forward_priority();
    do_reset();
    set_id(1, 0, 0, 5, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 0, 5, 0, 0, 1, 0);
    tick();
    set_id(1, 1, 5, 9, 1, 1, 1, 0);
    tick();
    total++; if ({forward_rd1_exe, forward_rd2_exe} !== 4'b0001) begin bad++; $display("FAIL fwd_mem_over_wb: got %b want 0001", {forward_rd1_exe, forward_rd2_exe}); end
    set_id(1, 5, 5, 10, 1, 0, 1, 0);
    tick();
    total++; if ({forward_rd1_exe, forward_rd2_exe} !== 4'b1000) begin bad++; $display("FAIL fwd_wb_unused_rs2: got %b want 1000", {forward_rd1_exe, forward_rd2_exe}); end
    set_id(0, 0, 0, 5, 0, 0, 1, 0);
    tick();
    set_id(1, 5, 0, 11, 1, 0, 1, 0);
    tick();
    total++; if (forward_rd1_exe !== 2'b00) begin bad++; $display("FAIL fwd_invalid_mem: got %b want 00", forward_rd1_exe); end
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 0, 0, 0, 0, 1, 0);
    tick();
    set_id(1, 0, 0, 12, 1, 1, 1, 0);
    tick();
    total++; if ({forward_rd1_exe, forward_rd2_exe} !== 4'b0000) begin bad++; $display("FAIL fwd_x0: got %b want 0000", {forward_rd1_exe, forward_rd2_exe}); end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 2, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 3, 8, 1, 1, 1, 0);
    #1;
    total++; if (ctrl() !== 4'b1101) begin bad++; $display("FAIL lu_detect_ctrl: got %b want 1101", ctrl()); end
    tick();
    total++; if (state !== 2'b01) begin bad++; $display("FAIL lu_state: got %b want 01", state); end
    total++; if (ctrl() !== 4'b0000) begin bad++; $display("FAIL lu_after_ctrl: got %b want 0000", ctrl()); end
    tick();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (state !== 2'b00) begin bad++; $display("FAIL lu_back_run: got %b want 00", state); end
    total++; if (stall_count !== 16'd1) begin bad++; $display("FAIL lu_count: got %0h want 1", stall_count); end
    total++; if ({forward_rd1_exe, forward_rd2_exe} !== 4'b1000) begin bad++; $display("FAIL lu_forward: got %b want 1000", {forward_rd1_exe, forward_rd2_exe}); end
  endtask

  task automatic test_no_valid();
    do_reset();
    set_id(1, 2, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(0, 7, 7, 8, 1, 1, 1, 0);
    #1;
    total++; if (ctrl() !== 4'b0000) begin bad++; $display("FAIL novalid_ctrl: got %b want 0000", ctrl()); end
    tick();
    total++; if ({state, stall_count} !== 18'd0) begin bad++; $display("FAIL novalid_state_count: got %b/%0h want 00/0", state, stall_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    set_id(1, 2, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 0, 8, 1, 0, 1, 0);
    redirect_exe = 1'b1;
    #1;
    total++; if (ctrl() !== 4'b0011) begin bad++; $display("FAIL redir_ctrl: got %b want 0011", ctrl()); end
    tick();
    redirect_exe = 1'b0;
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    total++; if (state !== 2'b10) begin bad++; $display("FAIL redir_state: got %b want 10", state); end
    total++; if (stall_count !== 16'd0) begin bad++; $display("FAIL redir_count: got %0h want 0", stall_count); end
    total++; if (ctrl() !== 4'b0000) begin bad++; $display("FAIL flush_one_cycle: got %b want 0000", ctrl()); end
    tick();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL flush_to_run: got %b want 00", state); end
  endtask

  task automatic test_mem_busy();
    do_reset();
    set_id(1, 2, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 0, 8, 1, 0, 1, 0);
    tick();
    mem_busy = 1'b1;
    #1;
    total++; if (ctrl() !== 4'b1100) begin bad++; $display("FAIL busy_ctrl: got %b want 1100", ctrl()); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if ({state, stall_count, ctrl()} !== {2'b01, 16'd1, 4'b1100}) begin bad++; $display("FAIL busy_hold%0d: got %b/%0h/%b want 01/1/1100", i, state, stall_count, ctrl()); end
    end
    mem_busy = 1'b0;
    tick();
    total++; if ({state, stall_count} !== {2'b00, 16'd1}) begin bad++; $display("FAIL busy_resume: got %b/%0h want 00/1", state, stall_count); end
  endtask

  task automatic load_use_pair();
    set_id(1, 2, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 0, 8, 1, 0, 1, 0);
    tick();
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    force dut.stall_count = 16'hFFFE;
    #1;
    release dut.stall_count;
    #1;
    total++; if (stall_count !== 16'hFFFE) begin bad++; $display("FAIL sat_preload: got %0h want fffe", stall_count); end
    load_use_pair();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_reach: got %0h want ffff", stall_count); end
    load_use_pair();
    total++; if (stall_count !== 16'hFFFF) begin bad++; $display("FAIL sat_hold: got %0h want ffff", stall_count); end
  endtask

  task automatic test_reset_mid_flush();
    do_reset();
    set_id(1, 2, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 0, 8, 1, 0, 1, 0);
    tick();
    set_id(1, 2, 0, 7, 1, 0, 1, 1);
    tick();
    set_id(1, 7, 0, 8, 1, 0, 1, 0);
    redirect_exe = 1'b1;
    tick();
    redirect_exe = 1'b0;
    #1;
    total++; if (state !== 2'b10) begin bad++; $display("FAIL pre_rst_state: got %b want 10", state); end
    #1;
    rst = 1'b1;
    #1;
    total++; if ({state, stall_count, ctrl(), forward_rd1_exe, forward_rd2_exe} !== 26'd0) begin bad++; $display("FAIL async_rst: got %b/%0h/%b/%b%b want all zero", state, stall_count, ctrl(), forward_rd1_exe, forward_rd2_exe); end
    rst = 1'b0;
    set_id(1, 7, 0, 8, 1, 0, 1, 0);
    #1;
    total++; if (ctrl() !== 4'b0000) begin bad++; $display("FAIL post_rst_empty_ex: got %b want 0000", ctrl()); end
    tick();
    total++; if (state !== 2'b00) begin bad++; $display("FAIL post_rst_state: got %b want 00", state); end
  endtask

  initial begin
    test_reset();
    test_forward_mem();
    test_forward_priority();
    test_load_use();
    test_no_valid();
    test_redirect();
    test_mem_busy();
    test_saturate();
    test_reset_mid_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
